// File: rtl/register_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_mp_if
// Description : Read/write/stack bus between the datapath and register_file_mp.
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_mp_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [DATA_W-1:0] rd_data_c;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        sp_op;
  logic              sp_fault_clr;
  logic [DATA_W-1:0] sp;
  logic              sp_fault;
  logic [DATA_W-1:0] out_port;

  modport master (
    output rd_addr_a, rd_addr_b, rd_addr_c, wr_en, wr_addr, wr_data, sp_op, sp_fault_clr,
    input  rd_data_a, rd_data_b, rd_data_c, sp, sp_fault, out_port
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, rd_addr_c, wr_en, wr_addr, wr_data, sp_op, sp_fault_clr,
    output rd_data_a, rd_data_b, rd_data_c, sp, sp_fault, out_port
  );
endinterface
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : register_file_mp
// Description : 3-read/1-write register file, r0 hardwired to zero, with a
//               bounds-checked stack pointer and a dedicated output register.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_mp #(
  parameter int              DATA_W    = 24,
  parameter int              ADDR_W    = 4,
  parameter int              NUM_REGS  = 16,
  parameter int              SP_ADDR   = 14,
  parameter int              OUT_ADDR  = 15,
  parameter int              SP_RESET  = 964,
  parameter int              SP_MIN    = 0,
  parameter int              SP_MAX    = 1023,
  parameter int              SP_STEP   = 1,
  parameter logic [DATA_W-1:0] OUT_RESET = '1,
  parameter int              BYPASS    = 1
) (
  input  logic               clk,
  input  logic               rst,
  register_file_mp_if.slave  bus
);

  localparam int              c_DEPTH      = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] c_STEP       = DATA_W'(SP_STEP);
  localparam logic [DATA_W-1:0] c_PUSH_FLOOR = DATA_W'(SP_MIN + SP_STEP);
  localparam logic [DATA_W-1:0] c_POP_CEIL   = DATA_W'(SP_MAX - SP_STEP);

  // Full address-space view: unimplemented slots and r0 read as zero.
  logic [DATA_W-1:0] w_view [c_DEPTH];
  logic [c_DEPTH-1:0] w_impl;

  logic              w_wrValid;
  logic              w_spWr;
  logic              w_push;
  logic              w_pop;
  logic              w_pushOk;
  logic              w_popOk;
  logic              w_spBad;
  logic [DATA_W-1:0] w_sp;
  logic [DATA_W-1:0] w_spNext;
  logic              r_spFault;

  assign w_wrValid = bus.wr_en & w_impl[bus.wr_addr];
  assign w_spWr    = w_wrValid && (bus.wr_addr == ADDR_W'(SP_ADDR));
  assign w_sp      = w_view[SP_ADDR];
  assign w_push    = (bus.sp_op == 2'b01);
  assign w_pop     = (bus.sp_op == 2'b10);
  assign w_pushOk  = (w_sp >= c_PUSH_FLOOR);
  assign w_popOk   = (w_sp <= c_POP_CEIL);
  // An explicit SP write supersedes push/pop, so no fault is raised under it.
  assign w_spBad   = !w_spWr && ((w_push && !w_pushOk) || (w_pop && !w_popOk));

  always_comb begin
    w_spNext = w_sp;
    if (w_push && w_pushOk) begin
      w_spNext = w_sp - c_STEP;
    end else if (w_pop && w_popOk) begin
      w_spNext = w_sp + c_STEP;
    end
  end

  for (genvar i = 0; i < c_DEPTH; i++) begin : g_slot
    if (i == 0 || i >= NUM_REGS) begin : g_none
      assign w_view[i] = '0;
      assign w_impl[i] = 1'b0;
    end else begin : g_reg
      localparam logic [DATA_W-1:0] c_RST = (i == SP_ADDR)  ? DATA_W'(SP_RESET) :
                                            (i == OUT_ADDR) ? OUT_RESET : '0;
      logic [DATA_W-1:0] r_q;
      logic [DATA_W-1:0] w_d;

      if (i == SP_ADDR) begin : g_sp
        assign w_d = w_spWr ? bus.wr_data : w_spNext;
      end else begin : g_gp
        assign w_d = (w_wrValid && bus.wr_addr == ADDR_W'(i)) ? bus.wr_data : r_q;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_q <= c_RST;
        end else begin
          r_q <= w_d;
        end
      end

      assign w_view[i] = r_q;
      assign w_impl[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_spFault <= 1'b0;
    end else if (w_spBad) begin
      r_spFault <= 1'b1;
    end else if (bus.sp_fault_clr) begin
      r_spFault <= 1'b0;
    end
  end

  logic [ADDR_W-1:0] w_rdAddr [3];
  logic [DATA_W-1:0] w_rdData [3];

  assign w_rdAddr[0] = bus.rd_addr_a;
  assign w_rdAddr[1] = bus.rd_addr_b;
  assign w_rdAddr[2] = bus.rd_addr_c;

  for (genvar p = 0; p < 3; p++) begin : g_rd
    assign w_rdData[p] = (BYPASS != 0 && w_wrValid && bus.wr_addr == w_rdAddr[p])
                         ? bus.wr_data : w_view[w_rdAddr[p]];
  end

  assign bus.rd_data_a = w_rdData[0];
  assign bus.rd_data_b = w_rdData[1];
  assign bus.rd_data_c = w_rdData[2];
  assign bus.sp        = w_sp;
  assign bus.sp_fault  = r_spFault;
  assign bus.out_port  = w_view[OUT_ADDR];

endmodule
`default_nettype wire
